// File: rtl/hero_motion.sv
// hero_motion: per-frame hero movement integrator (walk, jump arc, gravity).
// A frame counter divides clk_1ms into physics frames; all motion state
// updates on the edge that ends the last cycle of each frame.
// Optional feature macro: VARIABLE_JUMP_EN (releasing jump during the rise
// cuts the arc short). When undefined, every launched jump runs the full arc.
`timescale 1ns/1ps

module hero_motion #(
    parameter int FRAME_MS  = 16,
    parameter int X_INIT    = 32,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 608,
    parameter int GROUND_Y  = 400,
    parameter int WALK_STEP = 2,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int VMAX      = 8
) (
    input  logic       clk_1ms,
    input  logic       rst_n,
    input  logic       left,
    input  logic       right,
    input  logic       jump,
    output logic [9:0] hero_x,
    output logic [8:0] hero_y,
    output logic       facing_left,
    output logic       airborne,
    output logic       frame_tick
);

    localparam int CNT_W = $clog2(FRAME_MS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_MS - 1);

    localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
    localparam logic signed [11:0] STEP_S = 12'(WALK_STEP);

    localparam logic [4:0] JUMP_V5  = 5'(JUMP_V);
    localparam logic [4:0] GRAV5    = 5'(GRAVITY);
    localparam logic [4:0] VMAX5    = 5'(VMAX);
    localparam logic [9:0] GROUND10 = 10'(GROUND_Y);
    localparam logic [8:0] GROUND9  = 9'(GROUND_Y);
    localparam logic [9:0] XINIT10  = 10'(X_INIT);

    localparam logic [1:0] S_GROUND = 2'd0;
    localparam logic [1:0] S_RISE   = 2'd1;
    localparam logic [1:0] S_FALL   = 2'd2;

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             jump_p1;
    logic             jump_edge;
    logic             jump_req;
    logic [1:0]       state;
    logic [4:0]       vy;

    logic [1:0]       state_nx;
    logic [4:0]       vy_nx;
    logic [8:0]       y_nx;
    logic [9:0]       x_nx;
    logic             face_nx;
    logic [5:0]       v_fall;
    logic [9:0]       y_sum;
    logic             top_hit;

    // Move left by one step, clamped at the left edge.
    function automatic logic [9:0] walk_left(input logic [9:0] x);
        logic signed [11:0] t;
        t = $signed({2'b00, x}) - STEP_S;
        if (t < XMIN_S)
            t = XMIN_S;
        return t[9:0];
    endfunction

    // Move right by one step, clamped at the right edge.
    function automatic logic [9:0] walk_right(input logic [9:0] x);
        logic signed [11:0] t;
        t = $signed({2'b00, x}) + STEP_S;
        if (t > XMAX_S)
            t = XMAX_S;
        return t[9:0];
    endfunction

    assign tick      = (cnt == CNT_LAST);
    assign jump_edge = jump & ~jump_p1;
    assign airborne  = (state != S_GROUND);

    // Frame counter and registered frame pulse aligned with the new position.
    always_ff @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + CNT_W'(1);
            frame_tick <= tick;
        end
    end

    // Jump edge capture; the request lives for at most one frame.
    always_ff @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            jump_p1  <= 1'b0;
            jump_req <= 1'b0;
        end else begin
            jump_p1 <= jump;
            if (tick)
                jump_req <= 1'b0;
            else if (jump_edge)
                jump_req <= 1'b1;
        end
    end

    // Horizontal next position: walk only when exactly one direction is held.
    always_comb begin
        x_nx    = hero_x;
        face_nx = facing_left;
        if (left & ~right) begin
            x_nx    = walk_left(hero_x);
            face_nx = 1'b1;
        end else if (right & ~left) begin
            x_nx    = walk_right(hero_x);
            face_nx = 1'b0;
        end
    end

    // Vertical next state: launch, decelerating rise, accelerating fall, landing.
    always_comb begin
        state_nx = state;
        vy_nx    = vy;
        y_nx     = hero_y;
        v_fall   = '0;
        y_sum    = '0;
        top_hit  = 1'b0;
        case (state)
            S_GROUND: begin
                // An edge in the tick cycle itself still counts for this frame.
                if (jump_req | jump_edge) begin
                    state_nx = S_RISE;
                    vy_nx    = JUMP_V5;
                end
            end
            S_RISE: begin
                top_hit = (hero_y <= {4'd0, vy});
                y_nx    = top_hit ? 9'd0 : hero_y - {4'd0, vy};
                vy_nx   = vy - GRAV5;
                // Apex decided on the speed used this frame, so the last
                // GRAVITY-sized step is still applied before falling.
                if ((vy <= GRAV5) || top_hit) begin
                    state_nx = S_FALL;
                    vy_nx    = 5'd0;
                end
`ifdef VARIABLE_JUMP_EN
                if (!jump) begin
                    state_nx = S_FALL;
                    vy_nx    = 5'd0;
                    y_nx     = hero_y;
                end
`endif
            end
            S_FALL: begin
                v_fall = {1'b0, vy} + {1'b0, GRAV5};
                if (v_fall > {1'b0, VMAX5})
                    v_fall = {1'b0, VMAX5};
                y_sum = {1'b0, hero_y} + {4'd0, v_fall};
                if (y_sum >= GROUND10) begin
                    state_nx = S_GROUND;
                    vy_nx    = 5'd0;
                    y_nx     = GROUND9;
                end else begin
                    vy_nx = v_fall[4:0];
                    y_nx  = y_sum[8:0];
                end
            end
            default: begin
                state_nx = S_GROUND;
                vy_nx    = 5'd0;
                y_nx     = GROUND9;
            end
        endcase
    end

    // Motion registers: commit next values once per frame.
    always_ff @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            hero_x      <= XINIT10;
            hero_y      <= GROUND9;
            facing_left <= 1'b0;
            state       <= S_GROUND;
            vy          <= 5'd0;
        end else if (tick) begin
            hero_x      <= x_nx;
            hero_y      <= y_nx;
            facing_left <= face_nx;
            state       <= state_nx;
            vy          <= vy_nx;
        end
    end

endmodule
